// File: rtl/acq_capture.sv
// Multi-channel acquisition buffer writer: triggered, delayed,
// decimated capture of selected source streams into BRAM ports.
module acq_capture #(
  parameter int NSRC       = 8,
  parameter int NACQ       = 2,
  parameter int DATAWIDTH  = 256,
  parameter int ADDRWIDTH  = 9,
  parameter int SELW       = $clog2(NSRC),
  parameter int DELAYWIDTH = 32,
  parameter int DECWIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSRC*DATAWIDTH-1:0] src,
  input  logic [NACQ*SELW-1:0]      chansel,
  input  logic [NACQ-1:0]           chanen,
  input  logic                      stb_start,
  input  logic                      stb_stop,
  input  logic                      bufreset,
  input  logic                      mode,
  input  logic [DELAYWIDTH-1:0]     delayaftertrig,
  input  logic [DECWIDTH-1:0]       decimator,
  output logic [NACQ*DATAWIDTH-1:0] data,
  output logic [ADDRWIDTH-1:0]      addr,
  output logic [NACQ-1:0]           we,
  output logic                      busy,
  output logic                      done,
  output logic                      wrapped,
  output logic [ADDRWIDTH:0]        wrcnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_CAP,
    S_DONE
  } state_t;

  localparam logic [ADDRWIDTH:0] FULL =
    {1'b1, {ADDRWIDTH{1'b0}}};

  state_t                    state_q, state_d;
  logic [NACQ*SELW-1:0]      sel_q, sel_d;
  logic [NACQ-1:0]           en_q, en_d;
  logic                      mode_q, mode_d;
  logic [DECWIDTH-1:0]       dec_q, dec_d;
  logic [DECWIDTH-1:0]       cnt_q, cnt_d;
  logic [DELAYWIDTH-1:0]     dly_q, dly_d;
  logic [ADDRWIDTH-1:0]      wptr_q, wptr_d;
  logic [ADDRWIDTH-1:0]      addr_q, addr_d;
  logic [NACQ-1:0]           we_q, we_d;
  logic [NACQ*DATAWIDTH-1:0] data_q, data_d;
  logic                      wrapped_q, wrapped_d;
  logic [ADDRWIDTH:0]        wrcnt_q, wrcnt_d;
  logic [NACQ*DATAWIDTH-1:0] mux_data;

  // Out-of-range selects match no source and leave zero data
  always_comb begin
    mux_data = '0;
    for (int c = 0; c < NACQ; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (sel_q[c*SELW +: SELW] == SELW'(i)) begin
          mux_data[c*DATAWIDTH +: DATAWIDTH] =
            src[i*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    en_d      = en_q;
    mode_d    = mode_q;
    dec_d     = dec_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    wptr_d    = wptr_q;
    addr_d    = addr_q;
    we_d      = '0;
    data_d    = data_q;
    wrapped_d = wrapped_q;
    wrcnt_d   = wrcnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (stb_start) begin
          sel_d     = chansel;
          en_d      = chanen;
          mode_d    = mode;
          dec_d     = decimator;
          dly_d     = delayaftertrig;
          cnt_d     = '0;
          wptr_d    = '0;
          addr_d    = '0;
          wrcnt_d   = '0;
          wrapped_d = 1'b0;
          if (delayaftertrig != '0) begin
            state_d = S_DELAY;
          end else begin
            state_d = S_CAP;
          end
        end
      end
      S_DELAY: begin
        if (stb_stop) begin
          state_d = S_DONE;
        end else if (dly_q <= DELAYWIDTH'(1)) begin
          state_d = S_CAP;
        end else begin
          dly_d = dly_q - DELAYWIDTH'(1);
        end
      end
      S_CAP: begin
        if (stb_stop) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          we_d   = en_q;
          data_d = mux_data;
          addr_d = wptr_q;
          wptr_d = wptr_q + ADDRWIDTH'(1);
          cnt_d  = dec_q;
          if (wrcnt_q != FULL) begin
            wrcnt_d = wrcnt_q + (ADDRWIDTH+1)'(1);
          end
          // Top address: ring wraps, single-shot ends
          if (wptr_q == '1) begin
            if (mode_q) begin
              wrapped_d = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end else begin
          cnt_d = cnt_q - DECWIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || bufreset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      en_q      <= '0;
      mode_q    <= 1'b0;
      dec_q     <= '0;
      cnt_q     <= '0;
      dly_q     <= '0;
      wptr_q    <= '0;
      addr_q    <= '0;
      we_q      <= '0;
      data_q    <= '0;
      wrapped_q <= 1'b0;
      wrcnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      dec_q     <= dec_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      wptr_q    <= wptr_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      data_q    <= data_d;
      wrapped_q <= wrapped_d;
      wrcnt_q   <= wrcnt_d;
    end
  end

  assign data    = data_q;
  assign addr    = addr_q;
  assign we      = we_q;
  assign busy    = (state_q == S_DELAY) || (state_q == S_CAP);
  assign done    = (state_q == S_DONE);
  assign wrapped = wrapped_q;
  assign wrcnt   = wrcnt_q;

endmodule

// File: tb/tb_acq_capture.sv
// Randomized bench for acq_capture against a write-schedule model
// derived from trigger edge, delay, decimation and stop edge.
module tb_acq_capture;

  localparam int NSRC = 8;
  localparam int NACQ = 2;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int SELW = 4;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NSRC*DW-1:0]   src = '0;
  logic [NACQ*SELW-1:0] chansel = '0;
  logic [NACQ-1:0]      chanen = '0;
  logic                 stb_start = 1'b0;
  logic                 stb_stop = 1'b0;
  logic                 bufreset = 1'b0;
  logic                 mode = 1'b0;
  logic [31:0]          delayaftertrig = '0;
  logic [15:0]          decimator = '0;
  logic [NACQ*DW-1:0]   data;
  logic [AW-1:0]        addr;
  logic [NACQ-1:0]      we;
  logic                 busy;
  logic                 done;
  logic                 wrapped;
  logic [AW:0]          wrcnt;

  int errors = 0;
  int checks = 0;
  int ncnt = 0;

  int              obs_tag[$];
  logic [AW-1:0]   obs_addr[$];
  logic [NACQ*DW-1:0] obs_data[$];
  logic [NACQ-1:0] obs_we[$];

  acq_capture #(
    .NSRC(NSRC), .NACQ(NACQ), .DATAWIDTH(DW),
    .ADDRWIDTH(AW), .SELW(SELW),
    .DELAYWIDTH(32), .DECWIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .src(src),
    .chansel(chansel), .chanen(chanen),
    .stb_start(stb_start), .stb_stop(stb_stop),
    .bufreset(bufreset), .mode(mode),
    .delayaftertrig(delayaftertrig),
    .decimator(decimator), .data(data),
    .addr(addr), .we(we), .busy(busy),
    .done(done), .wrapped(wrapped), .wrcnt(wrcnt)
  );

  always #5 clk = ~clk;

  // Source word seen at posedge N is {stream, N}
  function automatic logic [DW-1:0] fsrc(input int i, input int n);
    logic [7:0] ib;
    logic [23:0] nb;
    ib = 8'(i);
    nb = 24'(n);
    if (i >= NSRC) return '0;
    return {ib, nb};
  endfunction

  always @(negedge clk) begin
    if (we !== '0) begin
      obs_tag.push_back(ncnt);
      obs_addr.push_back(addr);
      obs_data.push_back(data);
      obs_we.push_back(we);
    end
    ncnt++;
    for (int i = 0; i < NSRC; i++) src[i*DW +: DW] = fsrc(i, ncnt);
  end

  task automatic run_cap(input logic md, input int d, input int dc,
                         input int s0, input int s1,
                         input logic [1:0] en, input int stop_off,
                         input string nm);
    int k, guard, bound, n, e;
    int exp_tag[$];
    logic [NACQ*DW-1:0] exp_d;
    logic [3:0] sb0, sb1;
    obs_tag.delete(); obs_addr.delete();
    obs_data.delete(); obs_we.delete();
    sb0 = 4'(s0);
    sb1 = 4'(s1);
    @(posedge clk); #1;
    chansel = {sb1, sb0};
    chanen = en; mode = md;
    delayaftertrig = d; decimator = 16'(dc);
    stb_start = 1'b1;
    k = ncnt + 1;
    @(posedge clk); #1;
    stb_start = 1'b0;
    chansel = NACQ*SELW'($urandom);
    chanen = NACQ'($urandom);
    mode = 1'($urandom);
    delayaftertrig = $urandom_range(0, 7);
    decimator = 16'($urandom_range(0, 3));
    if (stop_off > 0) begin
      guard = 0;
      while (ncnt + 1 < k + stop_off && guard < 5000) begin
        @(posedge clk); #1;
        guard++;
      end
      stb_stop = 1'b1;
      @(posedge clk); #1;
      stb_stop = 1'b0;
    end
    bound = d + (DEPTH + 2) * (dc + 1) + 50;
    guard = 0;
    while (done !== 1'b1 && guard < bound) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b required 1", nm, done);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 1000; j++) begin
      e = k + 1 + d + j * (dc + 1);
      if (stop_off > 0 && e >= k + stop_off) break;
      if (!md && j >= DEPTH) break;
      exp_tag.push_back(e);
    end
    n = exp_tag.size();
    checks++;
    if (obs_tag.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d",
               nm, obs_tag.size(), n);
    end
    for (int j = 0; j < n && j < obs_tag.size(); j++) begin
      exp_d = {fsrc(s1, exp_tag[j]), fsrc(s0, exp_tag[j])};
      checks++;
      if (obs_tag[j] != exp_tag[j] || obs_addr[j] !== AW'(j % DEPTH)
          || obs_data[j] !== exp_d || obs_we[j] !== en) begin
        errors++;
        $display("FAIL %s write%0d: edge=%0d addr=%0d data=%h we=%b required edge=%0d addr=%0d data=%h we=%b",
                 nm, j, obs_tag[j], obs_addr[j], obs_data[j], obs_we[j],
                 exp_tag[j], j % DEPTH, exp_d, en);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || we !== '0) begin
      errors++;
      $display("FAIL %s end_flags: done=%b busy=%b we=%b required 1 0 00",
               nm, done, busy, we);
    end
    checks++;
    if (wrcnt !== (AW+1)'(n > DEPTH ? DEPTH : n)) begin
      errors++;
      $display("FAIL %s wrcnt: got %0d required %0d",
               nm, wrcnt, n > DEPTH ? DEPTH : n);
    end
    checks++;
    if (wrapped !== (md && n >= DEPTH)) begin
      errors++;
      $display("FAIL %s wrapped: got %b required %b",
               nm, wrapped, md && n >= DEPTH);
    end
    checks++;
    if (addr !== AW'(n > 0 ? (n - 1) % DEPTH : 0)) begin
      errors++;
      $display("FAIL %s end_addr: got %0d required %0d",
               nm, addr, n > 0 ? (n - 1) % DEPTH : 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (data !== '0 || addr !== '0 || we !== '0) begin
      errors++;
      $display("FAIL reset_bus: data=%h addr=%0d we=%b required 0",
               data, addr, we);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wrapped !== 1'b0
        || wrcnt !== '0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b wrapped=%b wrcnt=%0d required 0",
               busy, done, wrapped, wrcnt);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    run_cap(1'b0, 0, 0, 3, 5, 2'b11, 0, "single");
  endtask

  task automatic test_delay_decim();
    run_cap(1'b0, 5, 2, $urandom_range(0, 7), $urandom_range(0, 7),
            2'b11, 0, "delay_decim");
  endtask

  task automatic test_continuous();
    run_cap(1'b1, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7),
            2'b11, 41, "continuous");
  endtask

  task automatic test_stop_in_delay();
    run_cap(1'b0, 100, 0, 1, 2, 2'b11, 20, "stop_delay");
    run_cap(1'b0, $urandom_range(1, 4), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 7),
            2'b11, 0, "restart");
  endtask

  task automatic test_bufreset();
    @(posedge clk); #1;
    chansel = {4'd2, 4'd1}; chanen = 2'b11; mode = 1'b1;
    delayaftertrig = 0; decimator = 0;
    stb_start = 1'b1;
    @(posedge clk); #1;
    stb_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bufreset = 1'b1;
    stb_start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (we !== '0 || addr !== '0 || data !== '0) begin
      errors++;
      $display("FAIL bufreset_bus: we=%b addr=%0d data=%h required 0",
               we, addr, data);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wrcnt !== '0
        || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL bufreset_status: busy=%b done=%b wrcnt=%0d wrapped=%b required 0",
               busy, done, wrcnt, wrapped);
    end
    bufreset = 1'b0;
    stb_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || we !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bufreset_idle: busy=%b we=%b done=%b required 0",
               busy, we, done);
    end
  endtask

  task automatic test_bad_sel();
    run_cap(1'b0, 2, 1, 9, 4, 2'b01, 0, "bad_sel");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      run_cap(1'b1, $urandom_range(0, 6), $urandom_range(0, 2),
              $urandom_range(0, 9), $urandom_range(0, 9),
              2'($urandom_range(1, 3)), $urandom_range(30, 60),
              "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_delay_decim();
    test_continuous();
    test_stop_in_delay();
    test_bufreset();
    test_bad_sel();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
